// File: rtl/dbg_mem_ctrl.sv
// dbg_mem_ctrl: debug/loader controller in front of the SoC main memory port.
// Shares the single memory port between the CPU and a host command channel.
// Sequences CPU reset around program loading: halt, load or inspect words, run.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RUN      | CPU owns the memory port and is out of reset
// DRAIN    | CPU held in reset for one cycle so an in-flight CPU read completes
// HALTED   | debug owns the port, CPU in reset, waiting for commands
// WR       | debug write issued to memory this cycle
// RD_ISS   | debug read strobe issued to memory this cycle
// RD_CAP   | memory read data captured onto the response
// RELEASE  | port handed back to the CPU, CPU reset still held (hold counter)
// RSP      | one-cycle error response, then back to the originating state

module dbg_mem_ctrl #(
    parameter logic [31:0] MEM_BASE  = 32'h0002_0000,
    parameter int unsigned MEM_WORDS = 2048,
    parameter int unsigned RST_HOLD  = 4,
    parameter bit          BOOT_RUN  = 1'b0
) (
    input  logic        CLK,
    input  logic        RES,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_be,

    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_dat,

    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_do,
    input  logic [3:0]  cpu_wren,
    input  logic        cpu_rd,

    output logic [31:0] mem_adr,
    output logic [31:0] mem_do,
    output logic [3:0]  mem_wren,
    output logic        mem_rd,
    input  logic [31:0] mem_di,

    output logic        cpu_n_reset,
    output logic        dbg_active
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_WR,
        ST_RD_ISS,
        ST_RD_CAP,
        ST_RELEASE,
        ST_RSP
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    localparam int          HOLD_W    = 16;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

    // One past the last valid byte, in 33 bits so the compare cannot wrap.
    localparam logic [32:0] MEM_LO = {1'b0, MEM_BASE};
    localparam logic [32:0] MEM_HI = {1'b0, MEM_BASE} + (33'(MEM_WORDS) << 2);

    localparam state_t RESET_STATE = BOOT_RUN ? ST_RUN : ST_HALTED;
    localparam logic   RESET_NRST  = BOOT_RUN ? 1'b1 : 1'b0;

    state_t             state_q,       state_d;
    state_t             ret_q,         ret_d;
    logic [31:0]        adr_q,         adr_d;
    logic [31:0]        dat_q,         dat_d;
    logic [3:0]         be_q,          be_d;
    logic [HOLD_W-1:0]  hold_q,        hold_d;
    logic               rsp_valid_q,   rsp_valid_d;
    logic               rsp_err_q,     rsp_err_d;
    logic               cpu_n_reset_q, cpu_n_reset_d;

    logic               cmd_fire;
    logic               adr_ok;
    logic               cpu_owns;

    // Command acceptance and address legality for WRITE/READ.
    always_comb begin
        cmd_ready = (state_q == ST_RUN) || (state_q == ST_HALTED);
        cmd_fire  = cmd_valid && cmd_ready;
        adr_ok    = (cmd_adr[1:0] == 2'b00)
                 && ({1'b0, cmd_adr} >= MEM_LO)
                 && ({1'b0, cmd_adr} <  MEM_HI);
    end

    // Next-state, latched command fields, response and CPU reset control.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        be_d          = be_q;
        hold_d        = hold_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        cpu_n_reset_d = cpu_n_reset_q;

        case (state_q)
            ST_RUN: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_HALT: begin
                            state_d       = ST_DRAIN;
                            cpu_n_reset_d = 1'b0;
                        end
                        OP_RUN: begin
                            rsp_valid_d = 1'b1;
                        end
                        default: begin
                            // Memory access while the CPU runs is refused.
                            state_d     = ST_RSP;
                            ret_d       = ST_RUN;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end
            end

            ST_DRAIN: begin
                state_d     = ST_HALTED;
                rsp_valid_d = 1'b1;
            end

            ST_HALTED: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_HALT: begin
                            rsp_valid_d = 1'b1;
                        end
                        OP_WRITE: begin
                            if (adr_ok) begin
                                state_d     = ST_WR;
                                adr_d       = cmd_adr;
                                dat_d       = cmd_dat;
                                be_d        = cmd_be;
                                rsp_valid_d = 1'b1;
                            end else begin
                                state_d     = ST_RSP;
                                ret_d       = ST_HALTED;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (adr_ok) begin
                                state_d = ST_RD_ISS;
                                adr_d   = cmd_adr;
                            end else begin
                                state_d     = ST_RSP;
                                ret_d       = ST_HALTED;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_RELEASE;
                            hold_d  = HOLD_INIT;
                        end
                    endcase
                end
            end

            ST_WR: begin
                state_d = ST_HALTED;
            end

            ST_RD_ISS: begin
                state_d     = ST_RD_CAP;
                rsp_valid_d = 1'b1;
            end

            ST_RD_CAP: begin
                state_d = ST_HALTED;
            end

            ST_RELEASE: begin
                if (hold_q == '0) begin
                    state_d       = ST_RUN;
                    cpu_n_reset_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            ST_RSP: begin
                state_d = ret_q;
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any operation silently.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q       <= RESET_STATE;
            ret_q         <= RESET_STATE;
            adr_q         <= '0;
            dat_q         <= '0;
            be_q          <= '0;
            hold_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            cpu_n_reset_q <= RESET_NRST;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            be_q          <= be_d;
            hold_q        <= hold_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            cpu_n_reset_q <= cpu_n_reset_d;
        end
    end

    // Memory port mux and response outputs. Read data arrives one cycle after the
    // strobe, so it is steered straight from mem_di during RD_CAP rather than re-registered.
    always_comb begin
        cpu_owns = (state_q == ST_RUN) || (state_q == ST_RELEASE);
        if (cpu_owns) begin
            mem_adr  = cpu_adr;
            mem_do   = cpu_do;
            mem_wren = cpu_wren;
            mem_rd   = cpu_rd;
        end else begin
            mem_adr  = adr_q;
            mem_do   = dat_q;
            mem_wren = (state_q == ST_WR) ? be_q : 4'b0000;
            mem_rd   = (state_q == ST_RD_ISS);
        end
        rsp_valid   = rsp_valid_q;
        rsp_err     = rsp_err_q;
        rsp_dat     = (state_q == ST_RD_CAP) ? mem_di : 32'h0;
        cpu_n_reset = cpu_n_reset_q;
        dbg_active  = (state_q != ST_RUN);
    end

endmodule

// File: tb/tb_dbg_mem_ctrl.sv
// Directed bench for dbg_mem_ctrl with a small byte-enabled BRAM model.
module tb_dbg_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RES;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_do;
    logic [3:0]  cpu_wren;
    logic        cpu_rd;
    logic [31:0] mem_adr;
    logic [31:0] mem_do;
    logic [3:0]  mem_wren;
    logic        mem_rd;
    logic [31:0] mem_di;
    logic        cpu_n_reset;
    logic        dbg_active;

    int n_checks = 0;
    int n_fail   = 0;
    int wren_cnt = 0;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    always #5 CLK = ~CLK;

    dbg_mem_ctrl #(
        .MEM_BASE (32'h0002_0000),
        .MEM_WORDS(2048),
        .RST_HOLD (4),
        .BOOT_RUN (1'b0)
    ) dut (
        .CLK        (CLK),
        .RES        (RES),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .cmd_be     (cmd_be),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_dat    (rsp_dat),
        .cpu_adr    (cpu_adr),
        .cpu_do     (cpu_do),
        .cpu_wren   (cpu_wren),
        .cpu_rd     (cpu_rd),
        .mem_adr    (mem_adr),
        .mem_do     (mem_do),
        .mem_wren   (mem_wren),
        .mem_rd     (mem_rd),
        .mem_di     (mem_di),
        .cpu_n_reset(cpu_n_reset),
        .dbg_active (dbg_active)
    );

    // BRAM model: 2048 words at 0x20000, byte write enables, one-cycle read latency.
    logic [31:0] mem [0:2047];
    logic [10:0] mem_idx;
    assign mem_idx = 11'((mem_adr - 32'h0002_0000) >> 2);

    always @(posedge CLK) begin
        for (int b = 0; b < 4; b++)
            if (mem_wren[b]) mem[mem_idx][8*b +: 8] <= mem_do[8*b +: 8];
        if (mem_rd) mem_di <= mem[mem_idx];
        if (mem_wren != 4'b0000) wren_cnt <= wren_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command, then wait (bounded) for its response; checks latency, err, data
    // and that the response is a single-cycle pulse. rst_k = first cycle after T at which
    // cpu_n_reset changed (0 if it never changed before the response).
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] be,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_dat,
                          output int rst_k);
        int          lat;
        logic        rst0;
        logic        got_err;
        logic [31:0] got_dat;
        lat     = 0;
        rst_k   = 0;
        got_err = 1'b0;
        got_dat = 32'h0;
        @(negedge CLK);
        check_val({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        rst0      = cpu_n_reset;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_be    = be;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_adr   = ~adr;
        cmd_dat   = ~dat;
        cmd_be    = ~be;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (rst_k == 0 && cpu_n_reset !== rst0) rst_k = k;
            if (rsp_valid === 1'b1) begin
                lat     = k;
                got_err = rsp_err;
                got_dat = rsp_dat;
                break;
            end
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check_val({tag, "_dat"}, got_dat, exp_dat);
        @(negedge CLK);
        check_val({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rk;
        int          wc0;
        int          seen;
        logic [31:0] prog [0:5];

        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem_di    = 32'h0;
        RES       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_be    = 4'h0;
        cpu_adr   = 32'h0002_0004;
        cpu_do    = 32'hA5A5_5A5A;
        cpu_wren  = 4'h0;
        cpu_rd    = 1'b1;
        prog[0] = 32'h0000_0033; prog[1] = 32'h0000_0033; prog[2] = 32'h0000_0033;
        prog[3] = 32'hc020_2573; prog[4] = 32'hc000_2573; prog[5] = 32'h0000_006f;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RES = 1'b0;
        @(negedge CLK);
        check_val("rst_nreset",   32'(cpu_n_reset), 32'd0);
        check_val("rst_dbg",      32'(dbg_active),  32'd1);
        check_val("rst_ready",    32'(cmd_ready),   32'd1);
        check_val("rst_rsp",      32'(rsp_valid),   32'd0);
        check_val("rst_rsp_dat",  rsp_dat,          32'h0);
        check_val("halted_no_rd", 32'(mem_rd),      32'd0);

        // Program load and read-back
        for (int i = 0; i < 6; i++)
            do_cmd($sformatf("wr%0d", i), OP_WRITE, 32'h0002_0000 + 32'(4*i), prog[i], 4'hF,
                   1, 1'b0, 32'h0, rk);
        do_cmd("rd_2000c", OP_READ,  32'h0002_000C, 32'h0, 4'h0, 2, 1'b0, 32'hc020_2573, rk);
        do_cmd("rd_20000", OP_READ,  32'h0002_0000, 32'h0, 4'h0, 2, 1'b0, 32'h0000_0033, rk);
        do_cmd("wr_top",   OP_WRITE, 32'h0002_1FFC, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h0, rk);
        do_cmd("rd_top",   OP_READ,  32'h0002_1FFC, 32'h0, 4'h0, 2, 1'b0, 32'h1234_5678, rk);

        // Rejected accesses from HALTED: no memory write may happen
        wc0 = wren_cnt;
        do_cmd("wr_misal", OP_WRITE, 32'h0002_0002, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0, rk);
        do_cmd("wr_below", OP_WRITE, 32'h0001_FFFC, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0, rk);
        do_cmd("wr_above", OP_WRITE, 32'h0002_2000, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0, rk);
        do_cmd("rd_above", OP_READ,  32'h0002_2000, 32'h0, 4'h0, 1, 1'b1, 32'h0, rk);
        check_val("err_no_wren", 32'(wren_cnt - wc0), 32'd0);
        check_val("err_back_halted", 32'(dbg_active), 32'd1);
        do_cmd("rd_after_err", OP_READ, 32'h0002_0014, 32'h0, 4'h0, 2, 1'b0, 32'h0000_006f, rk);

        do_cmd("halt_halted", OP_HALT, 32'h0, 32'h0, 4'h0, 1, 1'b0, 32'h0, rk);
        check_val("halt_halted_nrst", 32'(rk), 32'd0);

        // RUN: reset released exactly 5 cycles after acceptance
        do_cmd("run", OP_RUN, 32'h0, 32'h0, 4'h0, 5, 1'b0, 32'h0, rk);
        check_val("run_nrst_k", 32'(rk), 32'd5);
        check_val("run_nrst",   32'(cpu_n_reset), 32'd1);
        check_val("run_dbg",    32'(dbg_active),  32'd0);
        check_val("run_mux_adr", mem_adr, cpu_adr);
        check_val("run_mux_rd",  32'(mem_rd), 32'd1);
        check_val("run_mux_do",  mem_do, cpu_do);

        do_cmd("run_run", OP_RUN, 32'h0, 32'h0, 4'h0, 1, 1'b0, 32'h0, rk);

        // Memory access refused while running, then halt and partial write
        wc0 = wren_cnt;
        do_cmd("rd_in_run", OP_READ,  32'h0002_0000, 32'h0, 4'h0, 1, 1'b1, 32'h0, rk);
        check_val("rd_in_run_back", 32'(dbg_active), 32'd0);
        do_cmd("wr_in_run", OP_WRITE, 32'h0002_0000, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0, rk);
        check_val("run_err_no_wren", 32'(wren_cnt - wc0), 32'd0);
        do_cmd("halt_run", OP_HALT, 32'h0, 32'h0, 4'h0, 2, 1'b0, 32'h0, rk);
        check_val("halt_nrst_k", 32'(rk), 32'd1);
        check_val("halt_nrst",   32'(cpu_n_reset), 32'd0);
        do_cmd("wr_be1", OP_WRITE, 32'h0002_000C, 32'h1122_3344, 4'b0010, 1, 1'b0, 32'h0, rk);
        do_cmd("rd_be1", OP_READ,  32'h0002_000C, 32'h0, 4'h0, 2, 1'b0, 32'hc020_3373, rk);

        // RES during RD_ISS
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_adr = 32'h0002_0000; cmd_be = 4'h0;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        check_val("rdiss_rd", 32'(mem_rd), 32'd1);
        RES = 1'b1;
        @(posedge CLK);
        #1 RES = 1'b0;
        seen = 0;
        @(negedge CLK);
        check_val("rdiss_res_ready", 32'(cmd_ready),   32'd1);
        check_val("rdiss_res_nrst",  32'(cpu_n_reset), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) seen++;
            @(negedge CLK);
        end
        check_val("rdiss_res_norsp", 32'(seen), 32'd0);

        // RES during RELEASE
        cmd_valid = 1'b1; cmd_op = OP_RUN;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        check_val("rel_mux_adr", mem_adr, cpu_adr);
        check_val("rel_nrst",    32'(cpu_n_reset), 32'd0);
        RES = 1'b1;
        @(posedge CLK);
        #1 RES = 1'b0;
        seen = 0;
        @(negedge CLK);
        check_val("rel_res_ready", 32'(cmd_ready),  32'd1);
        check_val("rel_res_dbg",   32'(dbg_active), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid || cpu_n_reset) seen++;
            @(negedge CLK);
        end
        check_val("rel_res_quiet", 32'(seen), 32'd0);
        check_val("rel_res_mem_rd", 32'(mem_rd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
